// File: rtl/ov7670_capture_dec.sv
// ov7670_capture_dec: OV7670 byte stream capture with integer decimation.
// Camera pins are oversampled in the clk domain and written to a frame buffer.
module ov7670_capture_dec #(
  parameter int c_img_cols     = 80,
  parameter int c_img_rows     = 60,
  parameter int c_nb_img_pxls  = 13,
  parameter int c_nb_buf_red   = 4,
  parameter int c_nb_buf_green = 4,
  parameter int c_nb_buf_blue  = 4,
  parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue,
  parameter int c_dec          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pclk,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               data,
  input  logic                     rgbmode,
  input  logic                     swap_r_b,
  input  logic                     capture_en,
  output logic [c_nb_img_pxls-1:0] addr,
  output logic [c_nb_buf-1:0]      dout,
  output logic                     we,
  output logic                     frame_done
);

  localparam int c_ph_w  = (c_dec > 1) ? $clog2(c_dec) : 1;
  localparam int c_col_w = $clog2(c_img_cols + 1);
  localparam int c_row_w = $clog2(c_img_rows + 1);
  localparam int c_last  = c_img_cols * c_img_rows - 1;

  localparam logic [c_ph_w-1:0]        c_ph_max  = c_ph_w'(c_dec - 1);
  localparam logic [c_col_w-1:0]       c_col_lim = c_col_w'(c_img_cols);
  localparam logic [c_row_w-1:0]       c_row_lim = c_row_w'(c_img_rows);
  localparam logic [c_nb_img_pxls-1:0] c_addr_max = c_nb_img_pxls'(c_last);

  logic [2:0]               pclk_s;
  logic [2:0]               vsync_s;
  logic [2:0]               href_s;
  logic [7:0]               data_s1;
  logic [7:0]               data_s2;

  logic                     pclk_rise;
  logic                     vsync_rise;
  logic                     href_fall;
  logic                     take;

  logic                     phase;
  logic [7:0]               first_byte;
  logic [c_ph_w-1:0]        col_ph;
  logic [c_ph_w-1:0]        row_ph;
  logic [c_col_w-1:0]       out_col;
  logic [c_row_w-1:0]       out_row;
  logic [c_nb_img_pxls-1:0] next_addr;
  logic                     active;
  logic                     mode_rgb;
  logic                     mode_swap;

  logic [4:0]               r5;
  logic [5:0]               g6;
  logic [4:0]               b5;
  logic [4:0]               rs;
  logic [4:0]               bs;
  logic [c_nb_buf-1:0]      pix;
  logic                     keep;

  // two-stage synchronisers plus a third pclk/href/vsync stage for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_s  <= '0;
      vsync_s <= '0;
      href_s  <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      pclk_s  <= {pclk_s[1:0], pclk};
      vsync_s <= {vsync_s[1:0], vsync};
      href_s  <= {href_s[1:0], href};
      data_s1 <= data;
      data_s2 <= data_s1;
    end
  end

  assign pclk_rise  = pclk_s[1] & ~pclk_s[2];
  assign vsync_rise = vsync_s[1] & ~vsync_s[2];
  assign href_fall  = href_s[2] & ~href_s[1];
  assign take       = pclk_rise & href_s[1] & ~vsync_s[1];

  assign keep = take & phase & active
              & (col_ph == '0) & (row_ph == '0)
              & (out_col < c_col_lim) & (out_row < c_row_lim);

  // assemble the stored word from the held first byte and the current byte
  always_comb begin
    r5 = first_byte[7:3];
    g6 = {first_byte[2:0], data_s2[7:5]};
    b5 = data_s2[4:0];
    rs = r5;
    bs = b5;
    if (mode_swap) begin
      rs = b5;
      bs = r5;
    end
    if (mode_rgb) begin
      pix = {c_nb_buf_red'(rs >> (5 - c_nb_buf_red)),
             c_nb_buf_green'(g6 >> (6 - c_nb_buf_green)),
             c_nb_buf_blue'(bs >> (5 - c_nb_buf_blue))};
    end else begin
      pix = {c_nb_buf_red'(first_byte >> (8 - c_nb_buf_red)),
             c_nb_buf_green'(first_byte >> (8 - c_nb_buf_green)),
             c_nb_buf_blue'(first_byte >> (8 - c_nb_buf_blue))};
    end
  end

  // frame/line bookkeeping, decimation and buffer writes
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      phase      <= 1'b0;
      first_byte <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      next_addr  <= '0;
      active     <= 1'b0;
      mode_rgb   <= 1'b1;
      mode_swap  <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (vsync_rise) begin
        phase      <= 1'b0;
        col_ph     <= '0;
        row_ph     <= '0;
        out_col    <= '0;
        out_row    <= '0;
        addr       <= '0;
        next_addr  <= '0;
        frame_done <= active;
        active     <= capture_en;
        mode_rgb   <= rgbmode;
        mode_swap  <= swap_r_b;
      end else if (href_fall) begin
        phase   <= 1'b0;
        col_ph  <= '0;
        out_col <= '0;
        row_ph  <= (row_ph == c_ph_max) ? '0 : row_ph + 1'b1;
        if (row_ph == '0 && out_row < c_row_lim) begin
          out_row <= out_row + 1'b1;
        end
      end else if (take) begin
        phase <= ~phase;
        if (!phase) begin
          first_byte <= data_s2;
        end else begin
          col_ph <= (col_ph == c_ph_max) ? '0 : col_ph + 1'b1;
          if (col_ph == '0 && row_ph == '0 && out_col < c_col_lim) begin
            out_col <= out_col + 1'b1;
          end
          if (keep) begin
            we   <= 1'b1;
            dout <= pix;
            addr <= next_addr;
            if (next_addr != c_addr_max) begin
              next_addr <= next_addr + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_dec.sv
// tb_ov7670_capture_dec: directed bench with write scoreboards.
// Instance a uses default geometry; instance b is a 4x3, undecimated buffer.
module tb_ov7670_capture_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        rgbmode;
  logic        swap_r_b;
  logic        cap_a;
  logic        cap_b;

  logic [12:0] addr_a;
  logic [11:0] dout_a;
  logic        we_a;
  logic        fd_a;
  logic [3:0]  addr_b;
  logic [11:0] dout_b;
  logic        we_b;
  logic        fd_b;

  typedef struct packed {
    logic [15:0] a;
    logic [11:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_chk = 0;
  int n_fail = 0;
  int fda = 0;
  int fdb = 0;
  int wra = 0;
  int wrb = 0;
  int lat;
  int wrb_snap;

  always #5 clk = ~clk;

  ov7670_capture_dec dut_a (
    .clk(clk), .rst(rst), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .rgbmode(rgbmode), .swap_r_b(swap_r_b),
    .capture_en(cap_a), .addr(addr_a), .dout(dout_a), .we(we_a),
    .frame_done(fd_a)
  );

  ov7670_capture_dec #(
    .c_img_cols(4), .c_img_rows(3), .c_nb_img_pxls(4), .c_dec(1)
  ) dut_b (
    .clk(clk), .rst(rst), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .rgbmode(rgbmode), .swap_r_b(swap_r_b),
    .capture_en(cap_b), .addr(addr_b), .dout(dout_b), .we(we_b),
    .frame_done(fd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rgb_w(input logic [7:0] b0,
                                        input logic [7:0] b1,
                                        input logic sw);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = b0[7:3];
    g = {b0[2:0], b1[7:5]};
    b = b1[4:0];
    if (sw) {r, b} = {b, r};
    return {r[4:1], g[5:2], b[4:1]};
  endfunction

  function automatic logic [7:0] ya(input int c);
    logic [15:0] cv;
    cv = 16'(c);
    return {cv[2:0], cv[3], 4'h0};
  endfunction

  // scoreboard: every write must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (we_a) begin
      wra++;
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL unexpected_we_a: observed addr %0d expected none", addr_a);
      end else begin
        e = qa.pop_front();
        check("addr_a", 32'(addr_a), 32'(e.a));
        check("dout_a", 32'(dout_a), 32'(e.d));
      end
    end
    if (we_b) begin
      wrb++;
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL unexpected_we_b: observed addr %0d expected none", addr_b);
      end else begin
        e = qb.pop_front();
        check("addr_b", 32'(addr_b), 32'(e.a));
        check("dout_b", 32'(dout_b), 32'(e.d));
      end
    end
    if (fd_a) fda++;
    if (fd_b) fdb++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pclk = 1'b0;
    data = b;
    tick();
    pclk = 1'b1;
    tick();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    tick(4);
  endtask

  task automatic line_on();
    href = 1'b1;
    tick();
  endtask

  task automatic line_off();
    pclk = 1'b0;
    href = 1'b0;
    tick(4);
  endtask

  task automatic push_b(input int a, input logic [11:0] d);
    qb.push_back('{a: 16'(a), d: d});
  endtask

  initial begin
    rst = 1'b1;
    pclk = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    data = 8'h00;
    rgbmode = 1'b1;
    swap_r_b = 1'b0;
    cap_a = 1'b1;
    cap_b = 1'b1;
    tick(2);
    check("rst_addr_a", 32'(addr_a), 0);
    check("rst_dout_a", 32'(dout_a), 0);
    check("rst_we_a", 32'(we_a), 0);
    check("rst_fd_a", 32'(fd_a), 0);
    check("rst_addr_b", 32'(addr_b), 0);
    check("rst_dout_b", 32'(dout_b), 0);
    check("rst_we_b", 32'(we_b), 0);
    rst = 1'b0;

    // camera activity without any vsync edge
    line_on();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(255)));
    line_off();
    check("idle_addr_a", 32'(addr_a), 0);
    check("idle_dout_a", 32'(dout_a), 0);
    check("idle_fd", 32'(fda + fdb), 0);
    check("idle_writes", 32'(wra + wrb), 0);

    // frame 1 on b: rgb, no swap, then swap asserted mid-frame
    cap_a = 1'b0;
    vs_pulse();
    check("first_vs_fd_b", 32'(fdb), 0);
    push_b(0, 12'hF00);
    line_on();
    send_byte(8'hF8);
    pclk = 1'b0;
    data = 8'h00;
    tick();
    pclk = 1'b1;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (we_b) break;
    end
    check("we_latency", 32'(lat), 4);
    line_off();
    swap_r_b = 1'b1;
    push_b(1, 12'hF00);
    line_on();
    send_byte(8'hF8);
    send_byte(8'h00);
    line_off();
    vs_pulse();
    check("fd_b_1", 32'(fdb), 1);

    // frame 2: swap latched; rgbmode change mid-frame is ignored
    push_b(0, 12'h00F);
    line_on();
    send_byte(8'hF8);
    send_byte(8'h00);
    line_off();
    rgbmode = 1'b0;
    push_b(1, rgb_w(8'hA5, 8'h3C, 1'b1));
    line_on();
    send_byte(8'hA5);
    send_byte(8'h3C);
    line_off();
    vs_pulse();
    check("fd_b_2", 32'(fdb), 2);

    // frame 3: yuv grey
    push_b(0, 12'hAAA);
    line_on();
    send_byte(8'hA5);
    send_byte(8'h3C);
    line_off();
    rgbmode = 1'b1;
    swap_r_b = 1'b0;
    vs_pulse();
    check("fd_b_3", 32'(fdb), 3);

    // frame 4: 6x6 source clipped to 4x3
    for (int r = 0; r < 6; r++) begin
      line_on();
      for (int c = 0; c < 6; c++) begin
        if (r < 3 && c < 4)
          push_b(r * 4 + c, rgb_w(8'(r * 40 + c * 7 + 3),
                                  8'(r * 13 + c * 29 + 5), 1'b0));
        send_byte(8'(r * 40 + c * 7 + 3));
        send_byte(8'(r * 13 + c * 29 + 5));
      end
      line_off();
    end
    check("clip_last_addr_b", 32'(addr_b), 11);
    check("clip_q_b", 32'(qb.size()), 0);
    wrb_snap = wrb;
    cap_b = 1'b0;
    vs_pulse();
    check("fd_b_4", 32'(fdb), 4);

    // frame 5: capture disabled
    line_on();
    send_byte(8'h11);
    send_byte(8'h22);
    line_off();
    cap_b = 1'b1;
    vs_pulse();
    check("off_fd_b", 32'(fdb), 4);
    check("off_writes_b", 32'(wrb - wrb_snap), 0);

    // frame 6: reset in the middle of a line
    push_b(0, rgb_w(8'h81, 8'h42, 1'b0));
    push_b(1, rgb_w(8'h7E, 8'hC3, 1'b0));
    line_on();
    send_byte(8'h81);
    send_byte(8'h42);
    send_byte(8'h7E);
    send_byte(8'hC3);
    tick(4);
    send_byte(8'h99);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    line_off();
    check("mid_rst_addr_b", 32'(addr_b), 0);
    check("mid_rst_dout_b", 32'(dout_b), 0);
    vs_pulse();
    check("post_rst_fd_b", 32'(fdb), 4);

    // frame 7: restart at addr 0; odd trailing byte is discarded
    push_b(0, rgb_w(8'h5A, 8'hA5, 1'b0));
    push_b(1, rgb_w(8'h0F, 8'hF0, 1'b0));
    push_b(2, rgb_w(8'h12, 8'h34, 1'b0));
    line_on();
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_byte(8'hF0);
    send_byte(8'hF8);
    line_off();
    line_on();
    send_byte(8'h12);
    send_byte(8'h34);
    line_off();
    cap_b = 1'b0;
    cap_a = 1'b1;
    rgbmode = 1'b0;
    vs_pulse();
    check("fd_b_7", 32'(fdb), 5);
    check("q_b_empty", 32'(qb.size()), 0);

    // frame 8 on a: decimation by 8 with column clipping, yuv
    line_on();
    for (int c = 0; c < 656; c++) begin
      if (c % 8 == 0 && c / 8 < 80)
        qa.push_back('{a: 16'(c / 8), d: {3{ya(c)[7:4]}}});
      send_byte(ya(c));
      send_byte(8'h55);
    end
    line_off();
    check("row0_writes_a", 32'(wra), 80);
    for (int r = 1; r < 8; r++) begin
      line_on();
      for (int c = 0; c < 16; c++) begin
        send_byte(ya(c));
        send_byte(8'h55);
      end
      line_off();
    end
    check("rows1_7_writes_a", 32'(wra), 80);
    qa.push_back('{a: 16'd80, d: {3{ya(0)[7:4]}}});
    qa.push_back('{a: 16'd81, d: {3{ya(8)[7:4]}}});
    line_on();
    for (int c = 0; c < 16; c++) begin
      send_byte(ya(c));
      send_byte(8'h55);
    end
    line_off();
    check("row8_addr_a", 32'(addr_a), 81);
    vs_pulse();
    check("fd_a", 32'(fda), 1);
    check("fd_b_final", 32'(fdb), 5);
    check("writes_a", 32'(wra), 82);
    check("q_a_empty", 32'(qa.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_dec.md
OV7670_CAPTURE_DEC -- requirements
Module: ov7670_capture_dec

Parameters
REQ-001 c_img_cols, 80, stored image width in pixels.
REQ-002 c_img_rows, 60, stored image height in pixels.
REQ-003 c_nb_img_pxls, 13, address width; must satisfy 2^c_nb_img_pxls >= c_img_cols*c_img_rows.
REQ-004 c_nb_buf_red, 4, red bits stored; range 1..5.
REQ-005 c_nb_buf_green, 4, green bits stored; range 1..6.
REQ-006 c_nb_buf_blue, 4, blue bits stored; range 1..5.
REQ-007 c_nb_buf, sum of the three channel widths, memory word width.
REQ-008 c_dec, 8, integer decimation factor applied on both axes; range 1..16.

Interface
REQ-009 clk  in  1  system clock (100 MHz); the block's only clock.
REQ-010 rst  in  1  reset; synchronous, active-high.
REQ-011 pclk  in  1  camera pixel clock, asynchronous; sampled as data.
REQ-012 vsync  in  1  camera vsync, asynchronous; high during frame blanking.
REQ-013 href  in  1  camera line-valid, asynchronous.
REQ-014 data  in  8  camera byte, asynchronous.
REQ-015 rgbmode  in  1  1 = RGB565, 0 = YUV422 (Y first).
REQ-016 swap_r_b  in  1  1 = exchange red and blue fields.
REQ-017 capture_en  in  1  0 = skip the next frame.
REQ-018 addr  out  c_nb_img_pxls  frame buffer write address.
REQ-019 dout  out  c_nb_buf  pixel word, {red, green, blue}, MSB first.
REQ-020 we  out  1  write strobe, one clk cycle per stored pixel.
REQ-021 frame_done  out  1  one-cycle pulse at the end of a captured frame.

Function
REQ-022 pclk, vsync, href and data SHALL each pass through 2 flip-flops; a pclk rising edge is detected from the 2nd and 3rd stages (edge cycle E).
REQ-023 Bytes SHALL be taken only at detected pclk edges with synchronised href=1 and vsync=0, using the data aligned with the same edge.
REQ-024 Each pair of bytes SHALL form one source pixel; a byte phase toggles per byte and clears at every href falling edge, so an odd trailing byte is discarded.
REQ-025 RGB565: byte0 = R[4:0],G[5:3]; byte1 = G[2:0],B[4:0]; each channel stores its top c_nb_buf_* bits.
REQ-026 YUV: only byte0 (Y) SHALL be used; every channel stores Y[7:8-c_nb_buf_*], giving grey.
REQ-027 swap_r_b=1 SHALL exchange the red and blue source fields before truncation.
REQ-028 Column and row phase counters SHALL count 0..c_dec-1 and wrap; a source pixel is kept only when both phases are 0.
REQ-029 Output column and row counters SHALL saturate at c_img_cols and c_img_rows; kept pixels beyond them are dropped (clipping).
REQ-030 A kept pixel SHALL drive dout and addr, with we=1 in cycle E+1 of its second byte; addr then increments by 1 and never exceeds c_img_cols*c_img_rows-1.
REQ-031 href falling edge: column phase and output column SHALL clear; row phase advances, and the output row advances when the row phase was 0.
REQ-032 vsync rising edge: all counters and addr SHALL clear; frame_done=1 for 1 cycle if the ending frame was active; rgbmode, swap_r_b and capture_en SHALL be latched for the next frame.
REQ-033 Frame inactive (latched capture_en=0): we SHALL stay 0 and frame_done SHALL not pulse for that frame.
REQ-034 A mode or capture_en change mid-frame SHALL have no effect until the next vsync rising edge.
REQ-035 The first frame after reset SHALL be discarded until a vsync rising edge is seen.

Reset
REQ-036 When rst=1 at a clk edge: addr=0, dout=0, we=0, frame_done=0; counters, byte phase and synchronisers are 0; the frame is inactive; the latched mode is rgbmode=1, swap=0.
REQ-037 Reset SHALL take priority over every event, including a pixel completing in the same cycle.

Verification
REQ-038 Assert rst for 2 cycles, then toggle the camera inputs with no vsync edge -> we, addr, dout and frame_done stay 0.
REQ-039 rgbmode=1, swap=0, c_dec=1, bytes 0xF8,0x00 -> dout=0xF00 at addr 0, with we=1 exactly 4 clk cycles after the raw second pclk rise; with swap=1 -> dout=0x00F.
REQ-040 rgbmode=0, bytes 0xA5,0x3C -> dout=0xAAA.
REQ-041 Defaults with a 640x480 frame -> 4800 writes; line 0 writes addr 0..79 from source cols 0,8,..,632; source rows 1..7 write nothing; row 8 starts at addr 80; last addr 4799; then one frame_done pulse.
REQ-042 c_dec=1 with a 640x480 frame -> writes clip at 80x60, last addr 4799, no addr wrap.
REQ-043 capture_en=0 at vsync rise -> no writes and no frame_done in that frame; rst asserted mid-line -> the next frame starts again at addr 0.
